// File: rtl/uart_receiver_if.sv
// ---------------------------------------------------------------------------
// uart_receiver_if
// Bundles the serial input and the received-byte outputs of uart_receiver.
//   RX        : serial line into the receiver, idle high
//   data      : last correctly received byte
//   valid     : one-cycle pulse when data has just been updated
//   busy      : high while a frame is being received
//   frame_err : one-cycle pulse when a frame ends with a bad stop bit
// The master modport is the side that drives the line and consumes bytes
// (a testbench or the surrounding system); the slave modport is the receiver.
// ---------------------------------------------------------------------------
interface uart_receiver_if;
   logic       RX;
   logic [7:0] data;
   logic       valid;
   logic       busy;
   logic       frame_err;

   modport master (
      output RX,
      input  data,
      input  valid,
      input  busy,
      input  frame_err
   );

   modport slave (
      input  RX,
      output data,
      output valid,
      output busy,
      output frame_err
   );
endinterface

// File: rtl/uart_receiver.sv
// ---------------------------------------------------------------------------
// uart_receiver
// 8N1 UART receiver: one start bit (0), eight data bits LSB first, one stop
// bit (1), no parity. The start bit is confirmed at its midpoint, and every
// later bit is sampled one full bit period after the previous sample, so the
// samples land near bit centres.
// Parameters:
//   CLKS_PER_BIT : clk cycles per serial bit (integer >= 4)
// Ports:
//   clk   : single clock, rising edge
//   reset : asynchronous, active-high reset
//   bus   : uart_receiver_if.slave (RX in; data, valid, busy, frame_err out)
// ---------------------------------------------------------------------------
module uart_receiver #(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic            clk,
   input  logic            reset,
   uart_receiver_if.slave  bus
);

   localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      WAIT_HIGH
   } state_t;

   state_t         state;
   logic [CW-1:0]  cnt;
   logic [2:0]     bit_idx;
   logic [7:0]     shift_reg;
   logic [7:0]     data_r;
   logic           valid_r;
   logic           frame_err_r;
   logic           busy_r;
   logic           rx_meta;
   logic           rx_s;

   assign bus.data      = data_r;
   assign bus.valid     = valid_r;
   assign bus.frame_err = frame_err_r;
   assign bus.busy      = busy_r;

   // RX is asynchronous to clk, so it goes through two flops before the FSM
   // ever looks at it. Both flops come out of reset at 1 (the idle line level)
   // so that releasing reset can never look like a falling start edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
      end else begin
         rx_meta <= bus.RX;
         rx_s    <= rx_meta;
      end
   end

   // Receive FSM. valid and frame_err default low every cycle so each is a
   // single-cycle pulse; they are set only in mutually exclusive branches of
   // the stop-bit decision. busy is registered and changes on the same edges
   // as the state, so it is high exactly while the FSM is in START, DATA or
   // STOP. A failed stop bit parks the FSM in WAIT_HIGH until the line goes
   // high again, otherwise a held-low line (break) would look like an endless
   // stream of start bits.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         cnt         <= '0;
         bit_idx     <= 3'd0;
         shift_reg   <= 8'h00;
         data_r      <= 8'h00;
         valid_r     <= 1'b0;
         frame_err_r <= 1'b0;
         busy_r      <= 1'b0;
      end else begin
         valid_r     <= 1'b0;
         frame_err_r <= 1'b0;
         case (state)
            IDLE: begin
               if (!rx_s) begin
                  state  <= START;
                  cnt    <= '0;
                  busy_r <= 1'b1;
               end
            end
            START: begin
               if (cnt == HALF_LAST) begin
                  cnt <= '0;
                  if (!rx_s) begin
                     state   <= DATA;
                     bit_idx <= 3'd0;
                  end else begin
                     state  <= IDLE;
                     busy_r <= 1'b0;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            DATA: begin
               if (cnt == BIT_LAST) begin
                  cnt                <= '0;
                  shift_reg[bit_idx] <= rx_s;
                  bit_idx            <= bit_idx + 3'd1;
                  if (bit_idx == 3'd7) begin
                     state <= STOP;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            STOP: begin
               if (cnt == BIT_LAST) begin
                  cnt    <= '0;
                  busy_r <= 1'b0;
                  if (rx_s) begin
                     data_r  <= shift_reg;
                     valid_r <= 1'b1;
                     state   <= IDLE;
                  end else begin
                     frame_err_r <= 1'b1;
                     state       <= WAIT_HIGH;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            WAIT_HIGH: begin
               if (rx_s) begin
                  state <= IDLE;
               end
            end
            default: begin
               state  <= IDLE;
               busy_r <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/uart_receiver.md
UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 The module SHALL have parameter CLKS_PER_BIT, default 16, meaning clk cycles per serial bit; legal values are integers >= 4.
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The module SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 The module SHALL have port RX, input, 1 bit: serial line, idle high, asynchronous to clk.
REQ-005 The module SHALL have port data, output, 8 bits: last correctly received byte.
REQ-006 The module SHALL have port valid, output, 1 bit: one-cycle pulse marking that data was updated.
REQ-007 The module SHALL have port busy, output, 1 bit: high while a frame is being received.
REQ-008 The module SHALL have port frame_err, output, 1 bit: one-cycle pulse on a bad stop bit.

Function
REQ-009 The frame format SHALL be 8N1: one start bit (0), 8 data bits LSB first, one stop bit (1), no parity.
REQ-010 RX SHALL pass through a 2-flop synchronizer (rx_s) before any use; both flops reset to 1.
REQ-011 Define N = CLKS_PER_BIT and H = N/2 (integer division); the bit-cycle counter SHALL be wide enough to hold N-1.
REQ-012 The FSM SHALL have the states IDLE, START, DATA, STOP and WAIT_HIGH.
REQ-013 IDLE: when rx_s = 0, go to START and clear the counter; otherwise stay in IDLE.
REQ-014 START: count H cycles; at count H-1, if rx_s = 0, go to DATA, clear the counter and clear the bit index; if rx_s = 1 (glitch), return to IDLE with no output pulse.
REQ-015 DATA: count N cycles per bit; at count N-1, shift rx_s into bit[index] and increment the index; after index 7 is sampled, go to STOP.
REQ-016 STOP: count N cycles; at count N-1, sample rx_s.
REQ-017 STOP with sample = 1: load data with the shift register, pulse valid for exactly 1 cycle, go to IDLE.
REQ-018 STOP with sample = 0: pulse frame_err for 1 cycle, leave data unchanged, keep valid low, go to WAIT_HIGH.
REQ-019 WAIT_HIGH: stay until rx_s = 1, then go to IDLE, so a held-low line (break) never starts a new frame.
REQ-020 Latency: with T0 the edge at which IDLE sees rx_s = 0, valid SHALL be high in the cycle after edge T0 + H + 9*N.
REQ-021 valid and frame_err SHALL never be high in the same cycle.
REQ-022 busy SHALL be 1 in START, DATA and STOP, and 0 in IDLE and WAIT_HIGH.
REQ-023 A new start bit arriving immediately after a stop-bit midpoint SHALL be detected (back-to-back frames).
REQ-024 data SHALL hold its value between valid pulses.

Reset
REQ-025 While reset = 1, regardless of clk: state = IDLE, counter = 0, bit index = 0, shift register = 0x00, data = 0x00, valid = 0, frame_err = 0, busy = 0, synchronizer flops = 1.
REQ-026 Reset asserted mid-frame SHALL abandon the frame with no valid or frame_err pulse.
REQ-027 After reset release, the first frame whose start edge arrives at least 2 cycles after release SHALL be received correctly.

Verification (N = 16)
REQ-028 Drive 0xA5 as 8N1 at 16 clk/bit -> exactly one valid pulse, data = 0xA5, frame_err = 0, busy high for H + 9*N cycles.
REQ-029 Pull RX low for 4 cycles, then return it high -> no valid, no frame_err, busy drops after H cycles, FSM back in IDLE.
REQ-030 Drive 0x3C with stop bit 0, then hold RX low for 40 cycles, then high -> one frame_err pulse, data keeps its prior value, no new frame starts until RX is high, then 0x11 is received correctly.
REQ-031 Drive 0x00 then 0xFF back-to-back, each with a single stop bit -> two valid pulses 10*N cycles apart, data = 0x00 then 0xFF.
REQ-032 Assert reset during data bit 3 of a frame, release it, then drive 0x5A -> all outputs 0 during reset, no pulse for the aborted frame, then data = 0x5A with one valid pulse.
REQ-033 Drive 0x81 with the bit period at N+1 cycles (about 6% slow) -> data = 0x81, valid pulses, no frame_err.
